argmax_classifier: RTL
======================

// Module: argmax_classifier
// PURPOSE
//  - Final stage of the MNIST pipeline; sits directly downstream of the last dense layer.
//  - Consumes one frame of NUM_CLASSES scores, one feature per beat, over feature_if (features[0]).
//  - Emits the index of the largest score as the predicted digit over a valid/ready result handshake.
//  - Counts completed classifications.
// PARAMETERS
//  NUM_CLASSES   10   scores per frame; must match OUTPUT_VECTOR_LENGTH of the upstream dense layer
//  INDEX_W       $clog2(NUM_CLASSES) (min 1)   width of the class index
//  COUNT_W       16   width of the frame counter
// PORTS
//  clock         in   1        system clock; all state updates on posedge
//  reset_n       in   1        asynchronous, active-low reset
//  features_in   if   feature_if  score stream; this block drives ready, samples valid/features[0]
//  class_valid   out  1        result available
//  class_ready   in   1        downstream accepts result
//  class_index   out  INDEX_W  predicted class, 0..NUM_CLASSES-1
//  frames_done   out  COUNT_W  number of results accepted downstream; saturates at all-ones
//  class_score   out  feature_type  winning score (present only with ARGMAX_SCORE_EN)
// BEHAVIOUR
//  - Reset values:
//    - state=COLLECT; beat count, class_index, frames_done, class_score = 0.
//    - class_valid=0; features_in.ready=1 once out of reset.
//  - FSM, state COLLECT:
//    - features_in.ready=1.
//    - Beat accepted when valid&&ready.
//    - Beat 0 loads max/index unconditionally.
//    - Later beats replace max/index only if score > max (signed compare on feature_type).
//    - Ties keep the lowest index. No fixed-point rescaling is applied.
//  - COLLECT -> RESULT:
//    - Transition on acceptance of beat NUM_CLASSES-1, using the updated max/index for that beat.
//    - class_valid asserts the cycle after the last beat: latency 1.
//  - FSM, state RESULT:
//    - features_in.ready=0; no beats consumed.
//    - class_valid=1; class_index/class_score held stable until class_ready.
//  - RESULT -> COLLECT:
//    - Transition on class_valid&&class_ready.
//    - Beat count cleared; frames_done += 1 unless saturated.
//    - features_in.ready reasserts the next cycle.
//    - Minimum frame period is NUM_CLASSES+1 cycles.
//  - Gaps in features_in.valid mid-frame are allowed: state and count hold.
//  - features_in.valid while in RESULT is ignored (ready=0); upstream must hold it.
//  - Reset mid-frame or mid-RESULT: immediate return to reset values; the partial frame is discarded.
//  - NUM_CLASSES=1: every frame yields index 0.
//  - Beat counter is INDEX_W wide; compare to NUM_CLASSES-1, never rely on wrap.
// CONFIGURATION
//  - ARGMAX_SCORE_EN defined:
//    - class_score port exists, carrying the winning feature_type value.
//    - Reset value 0; stable while class_valid=1.
//  - ARGMAX_SCORE_EN undefined:
//    - class_score port and its register are absent.
//    - All other behaviour is identical.
// STRUCTURE
//  - mnist_pkg:
//    - feature_type and feature_frac_bits (existing).
//    - New: NUM_DIGITS=10 constant.
//    - New: class_index_type = logic [$clog2(NUM_DIGITS)-1:0].
//  - Sub-module argmax_tracker:
//    - Inputs: load, update, score, idx. Outputs: max score, max index.
//    - Holds the running max/index register pair and the strict-greater comparator.
//  - argmax_classifier owns the FSM, beat counter, result handshake and frame counter.
// TESTING
//  1. Scores i<<feature_frac_bits for i=0..9 back-to-back, class_ready=1
//     -> class_index=9, class_valid 1 cycle after beat 9, frames_done=1.
//  2. All ten scores = 5
//     -> class_index=0 (tie keeps lowest).
//  3. Scores {-3,-1,-7,-9,-2,-8,-4,-6,-5,-10}
//     -> class_index=1 (signed compare).
//  4. class_ready low 5 cycles after the result
//     -> class_valid, class_index held stable; features_in.ready=0 throughout;
//        the next frame (max at index 4) is accepted after the handshake -> class_index=4, frames_done=2.
//  5. Random valid gaps in a frame with max at index 7
//     -> class_index=7.
//     Then reset_n low after 4 beats of a new frame
//     -> class_valid=0, frames_done=0; a following full frame (max at 2) -> class_index=2.
//  6. With ARGMAX_SCORE_EN, scores with max 37 at index 6
//     -> class_index=6, class_score=37.
//     Without the macro the bench compiles with no class_score port.

Source files
------------

// File: rtl/mnist_pkg.sv
// +--------------------------------------------------------------------+
// | mnist_pkg: shared types and constants for the MNIST pipeline       |
// | Revision: 1.1                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package mnist_pkg;

  typedef logic signed [15:0] feature_type;
  localparam int feature_frac_bits = 8;

  localparam int NUM_DIGITS = 10;
  typedef logic [$clog2(NUM_DIGITS)-1:0] class_index_type;

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_RESULT  = 1'b1
  } argmax_state_t;

endpackage

`default_nettype wire

// File: rtl/feature_if.sv
// +--------------------------------------------------------------------+
// | feature_if: valid/ready stream of feature vectors                  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

interface feature_if #(
  parameter int NUM_FEATURES = 1
);
  import mnist_pkg::*;

  logic        valid;
  logic        ready;
  feature_type features [NUM_FEATURES];

  modport sink   (input valid, input features, output ready);
  modport source (output valid, output features, input ready);
endinterface

`default_nettype wire

// File: rtl/argmax_tracker.sv
// +--------------------------------------------------------------------+
// | argmax_tracker: running max score / index register pair            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module argmax_tracker
  import mnist_pkg::*;
#(
  parameter int INDEX_W = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load,
  input  logic               update,
  input  feature_type        score,
  input  logic [INDEX_W-1:0] idx,
  output feature_type        max_score,
  output logic [INDEX_W-1:0] max_index
);

  feature_type        r_max_score;
  logic [INDEX_W-1:0] r_max_index;
  logic               w_greater;

  // Strictly greater so that ties keep the earliest index.
  assign w_greater = (score > r_max_score);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_max_score <= '0;
      r_max_index <= '0;
    end else if (load || (update && w_greater)) begin
      r_max_score <= score;
      r_max_index <= idx;
    end
  end

  assign max_score = r_max_score;
  assign max_index = r_max_index;

endmodule

`default_nettype wire

// File: rtl/argmax_classifier.sv
// +--------------------------------------------------------------------+
// | argmax_classifier: picks the highest-scoring class of each frame   |
// | Optional macro ARGMAX_SCORE_EN adds the class_score output.        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module argmax_classifier
  import mnist_pkg::*;
#(
  parameter int NUM_CLASSES = NUM_DIGITS,
  parameter int INDEX_W     = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
  parameter int COUNT_W     = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  feature_if.sink            features_in,
  output logic               class_valid,
  input  logic               class_ready,
  output logic [INDEX_W-1:0] class_index,
  output logic [COUNT_W-1:0] frames_done
`ifdef ARGMAX_SCORE_EN
  ,
  output feature_type        class_score
`endif
);

  localparam logic [INDEX_W-1:0] c_last_beat = INDEX_W'(NUM_CLASSES - 1);

  argmax_state_t      r_state;
  logic [INDEX_W-1:0] r_beat;
  logic               r_valid;
  logic               r_ready;
  logic [COUNT_W-1:0] r_frames;

  logic               w_accept;
  logic               w_last;
  logic               w_handshake;
  feature_type        w_max_score;

  assign w_accept    = features_in.valid && r_ready;
  assign w_last      = (r_beat == c_last_beat);
  assign w_handshake = r_valid && class_ready;

  argmax_tracker #(
    .INDEX_W (INDEX_W)
  ) u_tracker (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (w_accept && (r_beat == '0)),
    .update    (w_accept && (r_beat != '0)),
    .score     (features_in.features[0]),
    .idx       (r_beat),
    .max_score (w_max_score),
    .max_index (class_index)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_COLLECT;
      r_beat   <= '0;
      r_valid  <= 1'b0;
      r_ready  <= 1'b1;
      r_frames <= '0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (w_accept) begin
            if (w_last) begin
              r_beat  <= '0;
              r_state <= ST_RESULT;
              r_valid <= 1'b1;
              r_ready <= 1'b0;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        ST_RESULT: begin
          if (w_handshake) begin
            r_beat  <= '0;
            r_state <= ST_COLLECT;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            if (r_frames != '1) begin
              r_frames <= r_frames + 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_COLLECT;
          r_valid <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign class_valid       = r_valid;
  assign frames_done       = r_frames;
  assign features_in.ready = r_ready;

`ifdef ARGMAX_SCORE_EN
  assign class_score = w_max_score;
`endif

endmodule

`default_nettype wire
